// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM states, data width and baud divisor helper.
// Latency: n/a (declarations only).
// Backpressure: n/a. Used by both receive and transmit blocks.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  // Receive FSM states; PARITY is only reachable when UART_RX_PARITY_EN is defined.
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  // Clocks per oversample tick, rounded down.
  function automatic int uart_div(input int clk_hz, input int baud, input int oversample);
    return clk_hz / (baud * oversample);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running divider: emits a one-clock tick pulse every DIV clocks.
// Latency: first tick DIV clocks after reset release, then strictly periodic.
// Backpressure: none; the pulse is never held or stalled.
module uart_baud_tick #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // Count 0..DIV-1 and wrap on the tick; with DIV==1 the tick is constantly high.
  always_ff @(posedge clk) begin
    if (rst || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver (8 data bits, LSB first, optional even parity via UART_RX_PARITY_EN).
// Latency: byte and flags appear on rx_data/rx_valid 1 clk after the mid-stop-bit sample.
// Backpressure: one-entry holding register; a byte completing while it is still full is dropped and overrun pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BAUD_RATE   = 9600,
  parameter int OVERSAMPLE  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rxd,
  output logic [UART_DATA_W-1:0] rx_data,
  output logic                   rx_valid,
  input  logic                   rx_ready,
  output logic                   frame_err,
  output logic                   parity_err,
  output logic                   overrun,
  output logic                   busy
);

  localparam int            DIV    = uart_div(CLK_FREQ_HZ, BAUD_RATE, OVERSAMPLE);
  localparam int            SW     = $clog2(OVERSAMPLE);
  localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [2:0]    B_LAST = 3'(UART_DATA_W - 1);

  generate
    if (DIV < 1) begin : g_div_check
      $error("uart_rx: clock too slow for BAUD_RATE*OVERSAMPLE (divisor < 1)");
    end
    if ((OVERSAMPLE < 8) || ((OVERSAMPLE % 2) != 0)) begin : g_os_check
      $error("uart_rx: OVERSAMPLE must be even and at least 8");
    end
  endgenerate

  logic                   rxd_meta;
  logic                   rxd_sync;
  logic                   rxd_prev;
  logic                   start_edge;
  logic                   tick;

  rx_state_t              state, state_nxt;
  logic [SW-1:0]          scnt, scnt_nxt;
  logic [2:0]             bcnt, bcnt_nxt;
  logic [UART_DATA_W-1:0] shreg, shreg_nxt;
  logic                   done;
  logic                   load;
  logic                   par_calc_err;

`ifdef UART_RX_PARITY_EN
  logic                   par_bit, par_bit_nxt;
`endif

  uart_baud_tick #(
    .DIV (DIV)
  ) u_baud_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Two-flop synchroniser plus one history flop for edge detection; all preset to idle-high.
  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
      rxd_prev <= 1'b1;
    end else begin
      rxd_meta <= rxd;
      rxd_sync <= rxd_meta;
      rxd_prev <= rxd_sync;
    end
  end

  // Only a genuine 1->0 transition starts a frame, so a line held low cannot re-trigger.
  assign start_edge = rxd_prev & ~rxd_sync;

  // FSM and datapath state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      scnt    <= '0;
      bcnt    <= '0;
      shreg   <= '0;
`ifdef UART_RX_PARITY_EN
      par_bit <= 1'b0;
`endif
    end else begin
      state   <= state_nxt;
      scnt    <= scnt_nxt;
      bcnt    <= bcnt_nxt;
      shreg   <= shreg_nxt;
`ifdef UART_RX_PARITY_EN
      par_bit <= par_bit_nxt;
`endif
    end
  end

  // Next-state logic: the start bit is checked at mid-bit, after which every full bit period lands mid-bit.
  always_comb begin
    state_nxt   = state;
    scnt_nxt    = scnt;
    bcnt_nxt    = bcnt;
    shreg_nxt   = shreg;
    done        = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bit_nxt = par_bit;
`endif
    case (state)
      IDLE: begin
        if (start_edge) begin
          state_nxt = START;
          scnt_nxt  = '0;
        end
      end
      START: begin
        if (tick) begin
          if (scnt == S_MID) begin
            if (rxd_sync) begin
              state_nxt = IDLE;
            end else begin
              state_nxt = DATA;
              scnt_nxt  = '0;
              bcnt_nxt  = '0;
            end
          end else begin
            scnt_nxt = scnt + 1'b1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (scnt == S_LAST) begin
            scnt_nxt  = '0;
            shreg_nxt = {rxd_sync, shreg[UART_DATA_W-1:1]};
            bcnt_nxt  = bcnt + 3'd1;
            if (bcnt == B_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_nxt = PARITY;
`else
              state_nxt = STOP;
`endif
            end
          end else begin
            scnt_nxt = scnt + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick) begin
          if (scnt == S_LAST) begin
            scnt_nxt    = '0;
            par_bit_nxt = rxd_sync;
            state_nxt   = STOP;
          end else begin
            scnt_nxt = scnt + 1'b1;
          end
        end
      end
`endif
      STOP: begin
        if (tick) begin
          if (scnt == S_LAST) begin
            scnt_nxt  = '0;
            state_nxt = IDLE;
            done      = 1'b1;
          end else begin
            scnt_nxt = scnt + 1'b1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

`ifdef UART_RX_PARITY_EN
  // Even parity: data plus parity bit must XOR to zero.
  assign par_calc_err = ^{shreg, par_bit};
`else
  assign par_calc_err = 1'b0;
`endif

  // A finished byte may load only if the holding register is empty or being drained this cycle.
  assign load = done & (~rx_valid | rx_ready);

  // One-entry output register with error flags and overrun pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= done & ~load;
      if (load) begin
        rx_data    <= shreg;
        frame_err  <= ~rxd_sync;
        parity_err <= par_calc_err;
        rx_valid   <= 1'b1;
      end else if (rx_ready) begin
        rx_valid   <= 1'b0;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule
